// File: rtl/pc_gen_pkg.sv
// Shared PC-generator types and constants.
// PCGEN_HALT_EN adds the HALT state to the state encoding.
package pc_pkg;

    localparam int unsigned PC_W = 16;

    localparam logic [PC_W-1:0] DEFAULT_RESET_VECTOR = '0;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1
`ifdef PCGEN_HALT_EN
        ,
        ST_HALT = 2'd2
`endif
    } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-memory fetch channel between the PC generator and the imem.
interface pc_gen_if;
    import pc_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;

    modport master (output imem_req, output imem_addr, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_ready);

endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: boot/run FSM, fetch/decode PC registers and redirect handling.
// Define PCGEN_HALT_EN to add the halt input and terminal HALT state.
module pc_gen
    import pc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [PC_W-1:0] PC_INC       = 16'd1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
`ifdef PCGEN_HALT_EN
    input  logic            halt,
`endif
    pc_gen_if.master        bus,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic [PC_W-1:0] pc_link
);

    pc_state_e       state;
    logic [PC_W-1:0] fetch_pc;
    logic            accept;

    // Request is gated by the current-cycle stall/redirect so a redirect never races an accept.
    always_comb begin
        bus.imem_req  = (state == ST_RUN) && !stall && !redirect_valid;
        bus.imem_addr = fetch_pc;
        accept        = bus.imem_req && bus.imem_ready;
        pc_link       = pc + PC_INC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            fetch_pc <= RESET_VECTOR;
            pc       <= RESET_VECTOR;
            pc_valid <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_target;
                    end
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_target;
                        pc_valid <= 1'b0;
                    end else if (accept) begin
                        pc       <= fetch_pc;
                        pc_valid <= 1'b1;
                        fetch_pc <= fetch_pc + PC_INC;
                    end else if (!stall) begin
                        pc_valid <= 1'b0;
                    end
`ifdef PCGEN_HALT_EN
                    if (halt) begin
                        state <= ST_HALT;
                    end
`endif
                end
`ifdef PCGEN_HALT_EN
                ST_HALT: begin
                    pc_valid <= 1'b0;
                end
`endif
                default: begin
                    state    <= ST_BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
